// File: rtl/div_pkg.sv
// Shared width, count-width and state definitions for the sequential restoring divider.
package div_pkg;
    localparam int unsigned DIV_N = 8;
    localparam int unsigned CNT_W = $clog2(DIV_N + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} div_state_t;
endpackage

// File: rtl/seq_divider_8_if.sv
// Start/operand/result bundle between the Run-button top level and the divider.
interface seq_divider_8_if;
    logic                       Run;
    logic [div_pkg::DIV_N-1:0]  Dividend;
    logic [div_pkg::DIV_N-1:0]  Divisor;
    logic [div_pkg::DIV_N-1:0]  Quotient;
    logic [div_pkg::DIV_N-1:0]  Remainder;
    logic                       Done;
    logic                       Busy;
    logic                       DivByZero;

    modport master (
        output Run, Dividend, Divisor,
        input  Quotient, Remainder, Done, Busy, DivByZero
    );

    modport slave (
        input  Run, Dividend, Divisor,
        output Quotient, Remainder, Done, Busy, DivByZero
    );
endinterface

// File: rtl/shl_reg_8.sv
// Left-shift register with synchronous clear/load/shift (clear wins, then load).
module shl_reg_8
    import div_pkg::*;
(
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Load,
    input  logic             ShiftLeft,
    input  logic             shift_in,
    input  logic [DIV_N-1:0] D,
    output logic [DIV_N-1:0] Data_Out,
    output logic             msb_out
);

    always_ff @(posedge Clk) begin
        if (Clear) begin
            Data_Out <= '0;
        end else if (Load) begin
            Data_Out <= D;
        end else if (ShiftLeft) begin
            Data_Out <= {Data_Out[DIV_N-2:0], shift_in};
        end
    end

    assign msb_out = Data_Out[DIV_N-1];

endmodule

// File: rtl/seq_divider_8.sv
// Unsigned restoring divider, one quotient bit per clock; A:Q chained shift registers.
module seq_divider_8
    import div_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    seq_divider_8_if.slave  bus
);

    div_state_t         state;
    logic [DIV_N-1:0]   b_reg;
    logic [CNT_W-1:0]   cnt;
    logic               dbz_q;
    logic               done_q;
    logic               busy_q;

    logic [DIV_N-1:0]   a_val;
    logic [DIV_N-1:0]   q_val;
    logic               a_msb;
    logic               q_msb;

    logic               a_clear, a_load, a_shift;
    logic               q_clear, q_load, q_shift, q_in;
    logic [DIV_N-1:0]   a_d, q_d;

    logic [DIV_N:0]     p_val;
    logic [DIV_N:0]     diff;
    logic               borrow;

    // Trial subtraction of the divisor from the partial remainder shifted by one bit.
    assign p_val  = {a_msb, a_val[DIV_N-2:0], q_msb};
    assign diff   = p_val - {1'b0, b_reg};
    assign borrow = diff[DIV_N];

    // Register-pair control decoded from the current state.
    always_comb begin
        a_clear = 1'b0;
        a_load  = 1'b0;
        a_shift = 1'b0;
        a_d     = '0;
        q_clear = 1'b0;
        q_load  = 1'b0;
        q_shift = 1'b0;
        q_in    = 1'b0;
        q_d     = '0;
        if (Reset) begin
            a_clear = 1'b1;
            q_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Run) begin
                        q_load = 1'b1;
                        if (bus.Divisor != '0) begin
                            a_clear = 1'b1;
                            q_d     = bus.Dividend;
                        end else begin
                            a_load = 1'b1;
                            a_d    = bus.Dividend;
                            q_d    = '1;
                        end
                    end
                end
                ITER: begin
                    q_shift = 1'b1;
                    q_in    = ~borrow;
                    if (!borrow) begin
                        a_load = 1'b1;
                        a_d    = diff[DIV_N-1:0];
                    end else begin
                        a_shift = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    shl_reg_8 u_a_reg (
        .Clk       (Clk),
        .Clear     (a_clear),
        .Load      (a_load),
        .ShiftLeft (a_shift),
        .shift_in  (q_msb),
        .D         (a_d),
        .Data_Out  (a_val),
        .msb_out   (a_msb)
    );

    shl_reg_8 u_q_reg (
        .Clk       (Clk),
        .Clear     (q_clear),
        .Load      (q_load),
        .ShiftLeft (q_shift),
        .shift_in  (q_in),
        .D         (q_d),
        .Data_Out  (q_val),
        .msb_out   (q_msb)
    );

    // Sequencer; Done/Busy are registered alongside the state transitions.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            b_reg  <= '0;
            cnt    <= '0;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Run) begin
                        if (bus.Divisor != '0) begin
                            b_reg  <= bus.Divisor;
                            cnt    <= '0;
                            dbz_q  <= 1'b0;
                            state  <= ITER;
                            busy_q <= 1'b1;
                        end else begin
                            dbz_q  <= 1'b1;
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DIV_N - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.Run) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Quotient  = q_val;
    assign bus.Remainder = a_val;
    assign bus.Done      = done_q;
    assign bus.Busy      = busy_q;
    assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8.sv
// Randomized bench for seq_divider_8 against a plain-arithmetic division model.
module tb_seq_divider_8;
    import div_pkg::*;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    seq_divider_8_if dif ();

    seq_divider_8 dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (dif)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Division by definition; zero divisor yields all-ones quotient and the dividend as remainder.
    task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r, output logic z);
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input bit scramble, input string tag);
        logic [7:0] eq, er;
        logic       ez;
        int         busy_n;
        ref_div(a, b, eq, er, ez);
        @(negedge Clk);
        dif.Dividend = a;
        dif.Divisor  = b;
        dif.Run      = 1'b1;
        @(negedge Clk);
        dif.Run = 1'b0;
        busy_n  = 0;
        while (dif.Busy === 1'b1 && busy_n < 40) begin
            busy_n++;
            if (scramble) begin
                dif.Dividend = 8'($urandom);
                dif.Divisor  = 8'($urandom);
            end
            @(negedge Clk);
        end
        check({tag, " busy_cycles"}, 32'(busy_n), ez ? 32'd0 : 32'd8);
        check({tag, " done"},        32'(dif.Done),      32'd1);
        check({tag, " quotient"},    32'(dif.Quotient),  32'(eq));
        check({tag, " remainder"},   32'(dif.Remainder), 32'(er));
        check({tag, " divbyzero"},   32'(dif.DivByZero), 32'(ez));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " quotient"},  32'(dif.Quotient),  32'd0);
        check({tag, " remainder"}, 32'(dif.Remainder), 32'd0);
        check({tag, " done"},      32'(dif.Done),      32'd0);
        check({tag, " busy"},      32'(dif.Busy),      32'd0);
        check({tag, " divbyzero"}, 32'(dif.DivByZero), 32'd0);
    endtask

    initial begin
        int busy_n;
        int done_n;
        logic [7:0] a, b;

        Reset        = 1'b1;
        dif.Run      = 1'b0;
        dif.Dividend = 8'd0;
        dif.Divisor  = 8'd0;
        repeat (2) @(negedge Clk);
        check_cleared("reset");
        Reset = 1'b0;
        @(negedge Clk);
        check_cleared("idle_after_reset");

        run_div(8'd100, 8'd7, 1'b0, "100/7");
        run_div(8'd255, 8'd1, 1'b0, "255/1");
        run_div(8'd7,   8'd9, 1'b0, "7/9");
        run_div(8'd0,   8'd5, 1'b0, "0/5");
        run_div(8'd5,   8'd0, 1'b0, "5/0");
        run_div(8'd255, 8'd255, 1'b0, "255/255");
        run_div(8'd0,   8'd255, 1'b0, "0/255");
        run_div(8'd254, 8'd255, 1'b0, "254/255");
        run_div(8'd128, 8'd2, 1'b0, "128/2");
        run_div(8'd0,   8'd0, 1'b0, "0/0");

        // Reset in the fourth ITER cycle
        @(negedge Clk);
        dif.Dividend = 8'd100;
        dif.Divisor  = 8'd7;
        dif.Run      = 1'b1;
        @(negedge Clk);
        dif.Run = 1'b0;
        check("midreset busy_before", 32'(dif.Busy), 32'd1);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check_cleared("midreset");
        Reset = 1'b0;
        @(negedge Clk);
        check_cleared("midreset_idle");
        run_div(8'd200, 8'd13, 1'b0, "200/13");

        // Held Run must not restart after completion
        @(negedge Clk);
        dif.Dividend = 8'd50;
        dif.Divisor  = 8'd6;
        dif.Run      = 1'b1;
        busy_n = 0;
        done_n = 0;
        repeat (20) begin
            @(negedge Clk);
            if (dif.Busy === 1'b1) busy_n++;
            if (dif.Done === 1'b1) done_n++;
        end
        check("hold busy_cycles", 32'(busy_n), 32'd8);
        check("hold done_cycles", 32'(done_n), 32'd12);
        check("hold quotient",    32'(dif.Quotient),  32'd8);
        check("hold remainder",   32'(dif.Remainder), 32'd2);
        dif.Run      = 1'b0;
        dif.Dividend = 8'd9;
        dif.Divisor  = 8'd4;
        @(negedge Clk);
        check("released done",      32'(dif.Done),      32'd0);
        check("released quotient",  32'(dif.Quotient),  32'd8);
        check("released remainder", 32'(dif.Remainder), 32'd2);
        run_div(8'd9, 8'd4, 1'b0, "9/4");

        // Operands scrambled during ITER must not affect the result
        run_div(8'd100, 8'd7, 1'b1, "scramble 100/7");

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run_div(a, b, ($urandom_range(0, 1) == 1), "sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
